fixed_to_float_normalizer: RTL and testbench

//   Iterative normaliser. Converts a signed W-bit fixed-point operand (F fractional bits) into an IEEE-754 single or double word.
//   - One leading-zero shift per clock; Begin/ACK handshake.
//   - Parametrised successor of the single-precision linearizer/normalizer.
//   - Sits between fixed-point datapaths (CORDIC iterations, sensor scaling) and the floating-point units.

---
 rtl/fixed_to_float_normalizer.sv | 155 +++++++++++++++
 tb/tb_fixed_to_float_normalizer.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/fixed_to_float_normalizer.sv
// Signed W-bit fixed-point (F fractional bits) to IEEE-754 single/double converter, one leading-zero shift per clock.
// Latency: ACK_FSM lz+3 edges after the Begin_FSM sampling edge (2 for zero input, +1 with ROUND_NEAREST_EN for nonzero).
// Backpressure: none; Begin_FSM is honoured only in IDLE, ignored otherwise. Optional macro: ROUND_NEAREST_EN.
module fixed_to_float_normalizer #(
    parameter int P = 32,
    parameter int W = 32,
    parameter int F = 24
) (
    input  logic         CLK,
    input  logic         RST,
    input  logic         Begin_FSM,
    input  logic [W-1:0] DATA_IN,
    output logic         ACK_FSM,
    output logic         BUSY,
    output logic [P-1:0] RESULT,
    output logic         FLAG_ZERO
);

    localparam int EW       = (P == 64) ? 11 : 8;
    localparam int SW       = P - 1 - EW;
    localparam int BIAS     = (P == 64) ? 1023 : 127;
    localparam int EXP_BASE = BIAS + W - 1 - F;
    localparam int CW       = $clog2(W) + 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_SHIFT,
        S_PACK,
`ifdef ROUND_NEAREST_EN
        S_RND,
`endif
        S_DONE
    } state_t;

    state_t          state_q;
    logic [W-1:0]    op_q;
    logic [W-1:0]    mag_q;
    logic [CW-1:0]   cnt_q;
    logic            sign_q;
    logic            ack_q;
    logic            busy_q;
    logic [P-1:0]    result_q;
    logic            zero_q;

    // Exponent and fraction fields derived from the normalised magnitude
    logic [EW-1:0]   exp_d;
    logic [SW-1:0]   frac_d;
    logic [P-2:0]    packed_d;

`ifdef ROUND_NEAREST_EN
    // Hidden bit dropped; two extra zero bits keep guard/sticky indices legal even for W=2
    logic [W+SW:0]   ext_d;
    logic            guard_d;
    logic            sticky_d;
    logic            round_up_d;

    // Round-to-nearest-even; a mantissa carry ripples into the exponent through the joint add
    always_comb begin
        ext_d      = {mag_q[W-2:0], {(SW+2){1'b0}}};
        exp_d      = EW'(EXP_BASE) - EW'(cnt_q);
        frac_d     = SW'(ext_d >> (W + 1));
        guard_d    = ext_d[W];
        sticky_d   = |ext_d[W-1:0];
        round_up_d = guard_d & (sticky_d | frac_d[0]);
        packed_d   = {exp_d, frac_d} + {{(P-2){1'b0}}, round_up_d};
    end
`else
    // Truncation toward zero: keep the top SW bits below the hidden one, zero-padded when short
    always_comb begin
        exp_d    = EW'(EXP_BASE) - EW'(cnt_q);
        frac_d   = SW'({mag_q[W-2:0], {SW{1'b0}}} >> (W - 1));
        packed_d = {exp_d, frac_d};
    end
`endif

    // Conversion sequencer with registered handshake and result outputs
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q  <= S_IDLE;
            op_q     <= '0;
            mag_q    <= '0;
            cnt_q    <= '0;
            sign_q   <= 1'b0;
            ack_q    <= 1'b0;
            busy_q   <= 1'b0;
            result_q <= '0;
            zero_q   <= 1'b0;
        end else begin
            ack_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (Begin_FSM) begin
                        op_q    <= DATA_IN;
                        busy_q  <= 1'b1;
                        state_q <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    // The most negative operand negates to 2^(W-1), which fits as unsigned
                    sign_q  <= op_q[W-1];
                    mag_q   <= op_q[W-1] ? (~op_q + W'(1)) : op_q;
                    cnt_q   <= '0;
                    state_q <= (op_q == '0) ? S_PACK : S_SHIFT;
                end
                S_SHIFT: begin
                    if (mag_q[W-1]) begin
                        state_q <= S_PACK;
                    end else begin
                        mag_q <= mag_q << 1;
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                S_PACK: begin
                    if (mag_q == '0) begin
                        // Zero is reported as +0.0 regardless of sign
                        result_q <= '0;
                        zero_q   <= 1'b1;
                        ack_q    <= 1'b1;
                        state_q  <= S_DONE;
                    end else begin
                        result_q <= {sign_q, packed_d};
                        zero_q   <= 1'b0;
`ifdef ROUND_NEAREST_EN
                        state_q  <= S_RND;
`else
                        ack_q    <= 1'b1;
                        state_q  <= S_DONE;
`endif
                    end
                end
`ifdef ROUND_NEAREST_EN
                S_RND: begin
                    ack_q   <= 1'b1;
                    state_q <= S_DONE;
                end
`endif
                S_DONE: begin
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign ACK_FSM   = ack_q;
    assign BUSY      = busy_q;
    assign RESULT    = result_q;
    assign FLAG_ZERO = zero_q;

endmodule

// File: tb/tb_fixed_to_float_normalizer.sv
// Randomised scoreboard bench for fixed_to_float_normalizer at P=32, W=32, F=24.
// Expected words come from an arithmetic reference model (msb search, scaling, optional RNE).
// A negedge monitor pops expectations on every ACK_FSM and checks result, zero flag and latency.
module tb_fixed_to_float_normalizer;

    localparam int P = 32;
    localparam int W = 32;
    localparam int F = 24;
`ifdef ROUND_NEAREST_EN
    localparam int RL = 1;
`else
    localparam int RL = 0;
`endif

    logic         CLK = 1'b0;
    logic         RST;
    logic         Begin_FSM;
    logic [W-1:0] DATA_IN;
    logic         ACK_FSM;
    logic         BUSY;
    logic [P-1:0] RESULT;
    logic         FLAG_ZERO;

    fixed_to_float_normalizer #(.P(P), .W(W), .F(F)) dut (
        .CLK       (CLK),
        .RST       (RST),
        .Begin_FSM (Begin_FSM),
        .DATA_IN   (DATA_IN),
        .ACK_FSM   (ACK_FSM),
        .BUSY      (BUSY),
        .RESULT    (RESULT),
        .FLAG_ZERO (FLAG_ZERO)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [31:0] res;
        bit          fz;
        int          lat;
        int          start;
    } exp_t;

    exp_t sbq[$];
    int   n_vec = 0;
    int   n_err = 0;
    int   cyc   = 0;

    always @(posedge CLK) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Reference: value = DATA_IN / 2^F; exponent from the msb position, mantissa from the bits below it
    task automatic model(input logic [31:0] d, output logic [31:0] res, output bit fz, output int lat);
        longint      v;
        logic [63:0] m, below, frac, r;
        bit          sgn;
        int          p, e, sh;
`ifdef ROUND_NEAREST_EN
        logic [63:0] rem, half;
`endif
        v = longint'($signed(d));
        if (v == 0) begin
            res = 32'h0;
            fz  = 1'b1;
            lat = 2;
            return;
        end
        fz  = 1'b0;
        sgn = (v < 0);
        m   = sgn ? 64'(-v) : 64'(v);
        p   = 0;
        for (int i = 0; i < 64; i++) if (m[i]) p = i;
        e     = p - F + 127;
        below = m - (64'd1 << p);
        if (p <= 23) begin
            frac = below << (23 - p);
        end else begin
            sh   = p - 23;
            frac = below >> sh;
`ifdef ROUND_NEAREST_EN
            rem  = below & ((64'd1 << sh) - 64'd1);
            half = 64'd1 << (sh - 1);
            if (rem > half || (rem == half && frac[0])) frac = frac + 64'd1;
`endif
        end
        r   = (64'(e) << 23) + frac;
        res = {sgn, r[30:0]};
        lat = (31 - p) + 3 + RL;
    endtask

    // Monitor: every ACK must match the oldest outstanding start
    always @(negedge CLK) begin
        if (RST === 1'b0 && ACK_FSM === 1'b1) begin
            if (sbq.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL spurious_ack: ACK with no outstanding start, RESULT=%0h (cycle %0d)", RESULT, cyc);
            end else begin
                exp_t e;
                e = sbq.pop_front();
                check("result", 64'(RESULT), 64'(e.res));
                check("flag_zero", 64'(FLAG_ZERO), 64'(e.fz));
                check("latency", 64'(cyc - e.start), 64'(e.lat));
            end
        end
    end

    // Wait at negedges for IDLE, toggling Begin/DATA_IN randomly while busy (must be ignored)
    task automatic wait_idle(input bit noise);
        int w;
        w = 0;
        @(negedge CLK);
        while (BUSY !== 1'b0 && w < 400) begin
            Begin_FSM = noise ? 1'($urandom_range(0, 1)) : 1'b0;
            DATA_IN   = $urandom;
            @(negedge CLK);
            w++;
        end
        Begin_FSM = 1'b0;
        if (w >= 400) begin
            n_vec++;
            n_err++;
            $display("FAIL idle_timeout: BUSY=%0b after %0d cycles, expected 0", BUSY, w);
        end
    endtask

    task automatic start_exp(input logic [31:0] d, input logic [31:0] res, input bit fz, input int lat);
        exp_t e;
        wait_idle(1'b1);
        Begin_FSM = 1'b1;
        DATA_IN   = d;
        e.res     = res;
        e.fz      = fz;
        e.lat     = lat;
        e.start   = cyc + 1;
        sbq.push_back(e);
        @(negedge CLK);
        Begin_FSM = 1'($urandom_range(0, 1));
        DATA_IN   = $urandom;
    endtask

    task automatic start_model(input logic [31:0] d);
        logic [31:0] res;
        bit          fz;
        int          lat;
        model(d, res, fz, lat);
        start_exp(d, res, fz, lat);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] d;
        RST       = 1'b1;
        Begin_FSM = 1'b0;
        DATA_IN   = '0;
        repeat (3) @(negedge CLK);
        check("reset_ack", 64'(ACK_FSM), 64'd0);
        check("reset_busy", 64'(BUSY), 64'd0);
        check("reset_result", 64'(RESULT), 64'd0);
        check("reset_flag_zero", 64'(FLAG_ZERO), 64'd0);
        RST = 1'b0;

        // Known conversions with independently worked values
        start_exp(32'h00199999, 32'h3DCCCCC8, 1'b0, 14 + RL);
        start_exp(32'h01000000, 32'h3F800000, 1'b0, 10 + RL);
        start_exp(32'hFF800000, 32'hBF000000, 1'b0, 11 + RL);
        start_exp(32'h80000000, 32'hC3000000, 1'b0, 3 + RL);
        start_exp(32'h00000000, 32'h00000000, 1'b1, 2);
`ifdef ROUND_NEAREST_EN
        start_exp(32'h7FFFFFFF, 32'h43000000, 1'b0, 5);
`else
        start_exp(32'h7FFFFFFF, 32'h42FFFFFF, 1'b0, 4);
`endif
        start_exp(32'hFFFFFFFF, 32'hB3800000, 1'b0, 34 + RL);

        // Random operands spread across magnitudes, both signs, some zeros
        for (int i = 0; i < 300; i++) begin
            d = $urandom >> $urandom_range(0, 31);
            if ($urandom_range(0, 1) == 1) d = -d;
            if ($urandom_range(0, 19) == 0) d = 32'h0;
            start_model(d);
        end

        // Reset during SHIFT discards the conversion and clears outputs
        start_exp(32'h01000000, 32'h3F800000, 1'b0, 10 + RL);
        wait_idle(1'b0);
        start_exp(32'h00000001, 32'h0, 1'b0, 0);
        Begin_FSM = 1'b0;
        repeat (8) @(negedge CLK);
        RST = 1'b1;
        sbq.delete();
        @(negedge CLK);
        check("rst_busy", 64'(BUSY), 64'd0);
        check("rst_result", 64'(RESULT), 64'd0);
        check("rst_flag_zero", 64'(FLAG_ZERO), 64'd0);
        check("rst_ack", 64'(ACK_FSM), 64'd0);
        RST = 1'b0;
        repeat (40) @(negedge CLK);
        check("rst_idle_busy", 64'(BUSY), 64'd0);

        // Conversion after reset behaves normally
        start_model(32'hFE4CCCCD);
        wait_idle(1'b0);
        repeat (3) @(negedge CLK);
        check("pending_starts", 64'(sbq.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
